channel_mixer: RTL and testbench

//  Parametrised N-channel mixer. Sums Channel waveforms with per-channel gain/mute, master gain and saturation.
//  One time-multiplexed multiply-accumulate per sample, triggered by SampleTick. Bus-programmable.

---
 rtl/synth_pkg.sv | 29 ++
 rtl/mixer_regs.sv | 118 +++++++++++
 rtl/channel_mixer.sv | 157 +++++++++++++++
 tb/tb_channel_mixer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the synth voice blocks: wave/gain widths, mixer register
// offsets and the mixer FSM state encoding.
package synth_pkg;

  localparam int          WAVE_W     = 24;
  localparam int          GAIN_W     = 8;
  localparam logic [23:0] WAVE_MAX   = 24'hFFFFFF;
  localparam logic [7:0]  GAIN_UNITY = 8'h80;

  typedef logic [WAVE_W-1:0] wave_t;
  typedef logic [GAIN_W-1:0] gain_t;

  // Register offsets inside the 32-byte mixer window
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h01;
  localparam logic [4:0] OFF_MASTER  = 5'h02;
  localparam logic [4:0] OFF_MUTE_LO = 5'h04;
  localparam logic [4:0] OFF_MUTE_HI = 5'h05;
  localparam logic [4:0] OFF_PEAK0   = 5'h06;
  localparam logic [4:0] OFF_PEAK1   = 5'h07;
  localparam logic [4:0] OFF_PEAK2   = 5'h08;
  localparam logic [4:0] OFF_GAIN0   = 5'h10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_SCALE  = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

endpackage

// File: rtl/mixer_regs.sv
// Mixer register window: bus decode, gain/mute/master/CTRL registers, sticky
// flags and the combinational read mux. Peak hold exists only with MIXER_PEAK_HOLD_EN.
module mixer_regs
  import synth_pkg::*;
#(
  parameter int          NUM_CHANNELS = 2,
  parameter logic [15:0] BASE_ADDR    = 16'h0400
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [15:0]                i_bus_address,
  input  logic                       i_bus_write,
  input  logic [7:0]                 i_bus_write_data,
  input  logic                       i_busy,
  input  logic                       i_clip_set,
  input  logic                       i_overrun_set,
`ifdef MIXER_PEAK_HOLD_EN
  input  logic                       i_sample_valid,
  input  wave_t                      i_waveform,
`endif
  output logic                       o_enable,
  output logic [GAIN_W*NUM_CHANNELS-1:0] o_gains,
  output logic [NUM_CHANNELS-1:0]    o_mute,
  output gain_t                      o_master,
  output logic [7:0]                 o_read_data
);

  logic [15:0] w_off_full;
  logic [4:0]  w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_gain_hit;
  logic [3:0]  w_gain_idx;
  logic        w_clr;

  logic        r_enable;
  gain_t       r_master;
  logic [15:0] r_mute;
  gain_t       r_gain [NUM_CHANNELS];
  logic        r_clip;
  logic        r_overrun;

  // Subtraction wraps addresses below the base far out of the window
  assign w_off_full = i_bus_address - BASE_ADDR;
  assign w_hit      = (w_off_full[15:5] == 11'd0);
  assign w_off      = w_off_full[4:0];
  assign w_gain_idx = w_off[3:0];
  assign w_gain_hit = w_hit && w_off[4] && (32'(w_gain_idx) < NUM_CHANNELS);
  assign w_wr       = i_bus_write && w_hit;
  assign w_clr      = w_wr && (w_off == OFF_CTRL) && i_bus_write_data[1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_enable  <= 1'b0;
      r_master  <= GAIN_UNITY;
      r_mute    <= 16'h0000;
      r_clip    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) r_gain[i] <= GAIN_UNITY;
    end else begin
      if (w_wr && (w_off == OFF_CTRL))    r_enable     <= i_bus_write_data[0];
      if (w_wr && (w_off == OFF_MASTER))  r_master     <= i_bus_write_data;
      if (w_wr && (w_off == OFF_MUTE_LO)) r_mute[7:0]  <= i_bus_write_data;
      if (w_wr && (w_off == OFF_MUTE_HI)) r_mute[15:8] <= i_bus_write_data;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_wr && w_gain_hit && (w_gain_idx == 4'(i))) r_gain[i] <= i_bus_write_data;
      end
      r_clip    <= i_clip_set    | (r_clip    & ~w_clr);
      r_overrun <= i_overrun_set | (r_overrun & ~w_clr);
    end
  end

`ifdef MIXER_PEAK_HOLD_EN
  wave_t r_peak;
  wave_t w_peak_base;

  assign w_peak_base = w_clr ? '0 : r_peak;

  always_ff @(posedge i_clock) begin
    if (i_reset)                                       r_peak <= '0;
    else if (i_sample_valid && (i_waveform > w_peak_base)) r_peak <= i_waveform;
    else                                               r_peak <= w_peak_base;
  end
`endif

  always_comb begin
    o_read_data = 8'h00;
    if (w_hit) begin
      case (w_off)
        OFF_CTRL:    o_read_data = {7'd0, r_enable};
        OFF_STATUS:  o_read_data = {5'd0, r_overrun, r_clip, i_busy};
        OFF_MASTER:  o_read_data = r_master;
        OFF_MUTE_LO: o_read_data = r_mute[7:0];
        OFF_MUTE_HI: o_read_data = r_mute[15:8];
`ifdef MIXER_PEAK_HOLD_EN
        OFF_PEAK0:   o_read_data = r_peak[7:0];
        OFF_PEAK1:   o_read_data = r_peak[15:8];
        OFF_PEAK2:   o_read_data = r_peak[23:16];
`endif
        default: begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_gain_hit && (w_gain_idx == 4'(i))) o_read_data = r_gain[i];
          end
        end
      endcase
    end
  end

  always_comb begin
    o_gains = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) o_gains[GAIN_W*i +: GAIN_W] = r_gain[i];
  end

  assign o_enable = r_enable;
  assign o_master = r_master;
  assign o_mute   = r_mute[NUM_CHANNELS-1:0];

endmodule

// File: rtl/channel_mixer.sv
// N-channel mixer: time-multiplexed gain MAC per sample, master gain, headroom
// shift and saturation. Optional peak hold via MIXER_PEAK_HOLD_EN.
//   state  | meaning
//   IDLE   | waiting for SampleTick with enable set
//   ACCUM  | adding one gained channel per cycle
//   SCALE  | master gain, shift, saturate, update Waveform
//   OUTPUT | SampleValid high; back to IDLE
module channel_mixer
  import synth_pkg::*;
#(
  parameter int          NUM_CHANNELS   = 2,
  parameter logic [15:0] BASE_ADDR      = 16'h0400,
  parameter int          HEADROOM_SHIFT = $clog2(NUM_CHANNELS)
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [WAVE_W*NUM_CHANNELS-1:0] i_channel_waves,
  input  logic                           i_sample_tick,
  input  logic [15:0]                    i_bus_address,
  input  logic                           i_bus_write,
  input  logic [7:0]                     i_bus_write_data,
  output logic [7:0]                     o_bus_read_data,
  output logic [WAVE_W-1:0]              o_waveform,
  output logic                           o_sample_valid,
  output logic                           o_clip
);

  localparam int ACC_W  = 25 + $clog2(NUM_CHANNELS);
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = ACC_W + GAIN_W;

  logic                           w_enable;
  logic [GAIN_W*NUM_CHANNELS-1:0] w_gains;
  logic [NUM_CHANNELS-1:0]        w_mute;
  gain_t                          w_master;
  logic                           w_busy;
  logic                           w_clip_set;
  logic                           w_overrun_set;

  logic [1:0]              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [ACC_W-1:0]        r_acc;
  wave_t                   r_wave   [NUM_CHANNELS];
  gain_t                   r_gain_w [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_mute_w;
  gain_t                   r_master_w;
  wave_t                   r_waveform;
  logic                    r_valid;
  logic                    r_clip;

  wave_t             w_cur_wave;
  gain_t             w_cur_gain;
  logic              w_cur_mute;
  logic [31:0]       w_prod;
  logic [24:0]       w_term;
  logic [PROD_W-1:0] w_scaled;
  logic              w_sat;
  wave_t             w_wave_next;

  mixer_regs #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .BASE_ADDR    (BASE_ADDR)
  ) u_regs (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_bus_address    (i_bus_address),
    .i_bus_write      (i_bus_write),
    .i_bus_write_data (i_bus_write_data),
    .i_busy           (w_busy),
    .i_clip_set       (w_clip_set),
    .i_overrun_set    (w_overrun_set),
`ifdef MIXER_PEAK_HOLD_EN
    .i_sample_valid   (r_valid),
    .i_waveform       (r_waveform),
`endif
    .o_enable         (w_enable),
    .o_gains          (w_gains),
    .o_mute           (w_mute),
    .o_master         (w_master),
    .o_read_data      (o_bus_read_data)
  );

  always_comb begin
    w_cur_wave = '0;
    w_cur_gain = '0;
    w_cur_mute = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_wave = r_wave[i];
        w_cur_gain = r_gain_w[i];
        w_cur_mute = r_mute_w[i];
      end
    end
  end

  assign w_prod      = 32'(w_cur_wave) * 32'(w_cur_gain);
  assign w_term      = w_cur_mute ? 25'd0 : 25'(w_prod >> 7);
  assign w_scaled    = (PROD_W'(r_acc) * PROD_W'(r_master_w)) >> (7 + HEADROOM_SHIFT);
  assign w_sat       = (w_scaled > PROD_W'(WAVE_MAX));
  assign w_wave_next = w_sat ? WAVE_MAX : w_scaled[WAVE_W-1:0];

  assign w_busy        = (r_state != ST_IDLE);
  assign w_clip_set    = (r_state == ST_SCALE) && w_sat;
  assign w_overrun_set = i_sample_tick && w_enable && w_busy;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_mute_w   <= '0;
      r_master_w <= GAIN_UNITY;
      r_waveform <= '0;
      r_valid    <= 1'b0;
      r_clip     <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_wave[i]   <= '0;
        r_gain_w[i] <= GAIN_UNITY;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_sample_tick && w_enable) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              r_wave[i]   <= i_channel_waves[WAVE_W*i +: WAVE_W];
              r_gain_w[i] <= w_gains[GAIN_W*i +: GAIN_W];
            end
            r_mute_w   <= w_mute;
            r_master_w <= w_master;
            r_acc      <= '0;
            r_idx      <= '0;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc <= r_acc + ACC_W'(w_term);
          if (r_idx == IDX_W'(NUM_CHANNELS - 1)) r_state <= ST_SCALE;
          else                                   r_idx   <= r_idx + 1'b1;
        end
        ST_SCALE: begin
          r_waveform <= w_wave_next;
          r_clip     <= w_sat;
          r_valid    <= 1'b1;
          r_state    <= ST_OUTPUT;
        end
        ST_OUTPUT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_waveform     = r_waveform;
  assign o_sample_valid = r_valid;
  assign o_clip         = r_clip;

endmodule

// File: tb/tb_channel_mixer.sv
// Directed bench for channel_mixer: vector table on a 2-channel mixer plus
// hand-written multi-cycle sequences and a 4-channel instance for peak hold.
module tb_channel_mixer;

  localparam logic [15:0] A2 = 16'h0400;
  localparam logic [15:0] A4 = 16'h0800;
`ifdef MIXER_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] waves2 = '0;
  logic [95:0] waves4 = '0;
  logic        tick = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rd2, rd4;
  logic [23:0] wave2, wave4;
  logic        valid2, valid4, clip2, clip4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  channel_mixer #(.NUM_CHANNELS(2), .BASE_ADDR(A2)) dut (
    .i_clock(clk), .i_reset(rst), .i_channel_waves(waves2), .i_sample_tick(tick),
    .i_bus_address(addr), .i_bus_write(wr), .i_bus_write_data(wdata),
    .o_bus_read_data(rd2), .o_waveform(wave2), .o_sample_valid(valid2), .o_clip(clip2));

  channel_mixer #(.NUM_CHANNELS(4), .BASE_ADDR(A4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_channel_waves(waves4), .i_sample_tick(tick),
    .i_bus_address(addr), .i_bus_write(wr), .i_bus_write_data(wdata),
    .o_bus_read_data(rd4), .o_waveform(wave4), .o_sample_valid(valid4), .o_clip(clip4));

  typedef struct {
    logic [23:0] w0, w1;
    logic [7:0]  g0, g1, master;
    logic [15:0] mute;
    logic [23:0] exp_wave;
    logic        exp_clip;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic rd_check(input string name, input int sel, input logic [15:0] a, input logic [7:0] want);
    @(posedge clk); #1;
    addr = a;
    #2;
    check(name, (sel == 0) ? rd2 : rd4, want);
  endtask

  // Pulses tick, waits for SampleValid on the selected instance, then lets the FSM reach IDLE.
  task automatic run_sample(input int sel, output int lat, output logic [23:0] w, output logic c);
    lat = -1; w = '0; c = 1'b0;
    @(posedge clk); #1;
    tick = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) tick = 1'b0;
      if ((sel == 0) ? valid2 : valid4) begin
        lat = k;
        w = (sel == 0) ? wave2 : wave4;
        c = (sel == 0) ? clip2 : clip4;
        break;
      end
    end
    @(posedge clk); #1;
    check("valid_one_cycle", {31'd0, (sel == 0) ? valid2 : valid4}, 32'd0);
  endtask

  initial begin
    int          lat, nvalid;
    logic [23:0] w, got;
    logic        c;

    #200000;
    $display("FAIL watchdog: time limit reached, want test end");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, nvalid;
    logic [23:0] w, got;
    logic        c;

    //           w0          w1          g0     g1     master mute       exp_wave    clip
    vecs[0] = '{24'h400000, 24'h400000, 8'h80, 8'h80, 8'h80, 16'h0000, 24'h400000, 1'b0};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 24'hFFFFFF, 1'b1};
    vecs[2] = '{24'h800000, 24'hFFFFFF, 8'h40, 8'h80, 8'h40, 16'h0002, 24'h100000, 1'b0};
    vecs[3] = '{24'h123456, 24'h000100, 8'h80, 8'hFF, 8'h80, 16'h0000, 24'h091B2A, 1'b0};
    vecs[4] = '{24'hFFFFFF, 24'hFFFFFF, 8'h80, 8'h80, 8'h80, 16'h0000, 24'hFFFFFF, 1'b0};
    vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 8'h81, 8'h81, 8'h80, 16'h0000, 24'hFFFFFF, 1'b1};
    vecs[6] = '{24'h000000, 24'h000000, 8'h80, 8'h80, 8'h80, 16'h0000, 24'h000000, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_wave", {8'd0, wave2}, 32'd0);
    check("rst_valid", {31'd0, valid2}, 32'd0);
    check("rst_clip", {31'd0, clip2}, 32'd0);
    rd_check("rst_ctrl", 0, A2 + 16'h00, 8'h00);
    rd_check("rst_status", 0, A2 + 16'h01, 8'h00);
    rd_check("rst_master", 0, A2 + 16'h02, 8'h80);
    rd_check("rst_gain0", 0, A2 + 16'h10, 8'h80);
    rd_check("rst_gain1", 0, A2 + 16'h11, 8'h80);
    rd_check("rst_mute_lo", 0, A2 + 16'h04, 8'h00);
    rd_check("unmapped_gain2", 0, A2 + 16'h12, 8'h00);
    rd_check("unmapped_03", 0, A2 + 16'h03, 8'h00);

    // Unmapped write leaves mapped registers untouched
    bus_wr(A2 + 16'h12, 8'h11);
    rd_check("gain1_after_unmapped_wr", 0, A2 + 16'h11, 8'h80);

    // Tick while disabled: no sample, no overrun
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (valid2) nvalid++;
    end
    check("disabled_no_valid", nvalid, 0);
    rd_check("disabled_status", 0, A2 + 16'h01, 8'h00);

    bus_wr(A2 + 16'h00, 8'h01);
    rd_check("ctrl_enable", 0, A2 + 16'h00, 8'h01);

    for (int v = 0; v < 7; v++) begin
      bus_wr(A2 + 16'h10, vecs[v].g0);
      bus_wr(A2 + 16'h11, vecs[v].g1);
      bus_wr(A2 + 16'h02, vecs[v].master);
      bus_wr(A2 + 16'h04, vecs[v].mute[7:0]);
      waves2 = {vecs[v].w1, vecs[v].w0};
      run_sample(0, lat, w, c);
      check($sformatf("vec%0d_wave", v), {8'd0, w}, {8'd0, vecs[v].exp_wave});
      check($sformatf("vec%0d_clip", v), {31'd0, c}, {31'd0, vecs[v].exp_clip});
      check($sformatf("vec%0d_latency", v), lat, 4);
      if (v == 1) begin
        rd_check("clip_status", 0, A2 + 16'h01, 8'h02);
        bus_wr(A2 + 16'h00, 8'h03);
        rd_check("clip_status_cleared", 0, A2 + 16'h01, 8'h00);
        rd_check("ctrl_bit1_reads0", 0, A2 + 16'h00, 8'h01);
      end
    end
    check("clip_held_low", {31'd0, clip2}, 32'd0);

    // Snapshot and overrun: second tick plus gain write while accumulating
    bus_wr(A2 + 16'h00, 8'h03);
    bus_wr(A2 + 16'h10, 8'h80);
    bus_wr(A2 + 16'h11, 8'h80);
    bus_wr(A2 + 16'h02, 8'h80);
    bus_wr(A2 + 16'h04, 8'h00);
    waves2 = {24'h400000, 24'h400000};
    @(posedge clk); #1 tick = 1'b1;
    nvalid = 0; got = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        addr = A2 + 16'h10; wdata = 8'h00; wr = 1'b1;
      end
      if (k == 2) begin
        tick = 1'b0; wr = 1'b0;
      end
      if (valid2) begin
        nvalid++;
        got = wave2;
      end
    end
    check("snap_wave_old_gain", {8'd0, got}, 32'h00400000);
    check("snap_one_valid", nvalid, 1);
    rd_check("overrun_status", 0, A2 + 16'h01, 8'h04);
    rd_check("snap_gain0_new", 0, A2 + 16'h10, 8'h00);
    run_sample(0, lat, w, c);
    check("next_uses_new_gain", {8'd0, w}, 32'h00200000);

    // Reset one cycle after tick
    bus_wr(A2 + 16'h10, 8'h55);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (valid2) nvalid++;
    end
    check("rst_mid_no_valid", nvalid, 0);
    check("rst_mid_wave", {8'd0, wave2}, 32'd0);
    rd_check("rst_mid_gain0", 0, A2 + 16'h10, 8'h80);
    rd_check("rst_mid_ctrl", 0, A2 + 16'h00, 8'h00);
    rd_check("rst_mid_status", 0, A2 + 16'h01, 8'h00);

    // Four-channel instance with peak hold
    bus_wr(A4 + 16'h00, 8'h01);
    rd_check("n4_gain3", 1, A4 + 16'h13, 8'h80);
    rd_check("n4_unmapped_gain4", 1, A4 + 16'h14, 8'h00);
    waves4 = {4{24'h100000}};
    run_sample(1, lat, w, c);
    check("n4_s0_wave", {8'd0, w}, 32'h00100000);
    check("n4_latency", lat, 6);
    waves4 = {4{24'h300000}};
    run_sample(1, lat, w, c);
    check("n4_s1_wave", {8'd0, w}, 32'h00300000);
    waves4 = {4{24'h200000}};
    run_sample(1, lat, w, c);
    check("n4_s2_wave", {8'd0, w}, 32'h00200000);
    rd_check("peak0", 1, A4 + 16'h06, 8'h00);
    rd_check("peak1", 1, A4 + 16'h07, 8'h00);
    rd_check("peak2", 1, A4 + 16'h08, PEAK_EN ? 8'h30 : 8'h00);
    bus_wr(A4 + 16'h00, 8'h03);
    rd_check("peak0_clr", 1, A4 + 16'h06, 8'h00);
    rd_check("peak1_clr", 1, A4 + 16'h07, 8'h00);
    rd_check("peak2_clr", 1, A4 + 16'h08, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
